// File: rtl/instr_issue.sv
// instr_issue: program buffer and issue stage for the 19-bit datapath
// (opcode[18:15], WA[14:10], RA1[9:5], RA2[4:0]). The host loads words while
// IDLE. On start the program is issued one word per cycle. NOP bubbles are
// inserted whenever a read would see a register that an in-flight writer has
// not yet produced. After the last word the pipeline drains, then done pulses.
// Optional feature macro: INSTR_ISSUE_STALL_CNT_EN adds a 16-bit saturating
// counter of hazard bubbles on output stall_cnt.
module instr_issue #(
  parameter int          AW          = 4,
  parameter logic [3:0]  NOP_OPCODE  = 4'hF,
  parameter logic [15:0] WR_MASK     = 16'h00FF,
  parameter int          HAZARD_DIST = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [18:0]   ld_data,
  input  logic          clear,
  input  logic          start,
  output logic [18:0]   instruccion,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   issued_cnt
`ifdef INSTR_ISSUE_STALL_CNT_EN
  , output logic [15:0] stall_cnt
`endif
);

  localparam int          DEPTH = 1 << AW;
  // The history array needs at least one slot to be legal, even when
  // HAZARD_DIST = 1 leaves it permanently invalid.
  localparam int          HL    = (HAZARD_DIST > 1) ? HAZARD_DIST - 1 : 1;
  localparam logic [18:0] NOP_W = {NOP_OPCODE, 15'b0};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t      state_q;
  logic [18:0] mem [DEPTH];
  logic [AW:0] count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0] issued_q;
  logic [2:0]  drain_q;
  logic [18:0] instr_q;
  logic        busy_q, done_q;
  logic        hv_q [HL];
  logic [4:0]  hw_q [HL];

  logic [18:0] cand;
  logic        cand_wr, hazard, ld_we, go_start, last_word;
  logic [AW:0] count_m1;

  assign cand      = mem[rd_ptr_q];
  assign cand_wr   = (cand[18:15] != NOP_OPCODE) && WR_MASK[cand[18:15]];
  // count is never above DEPTH, so its top bit alone means "full"
  assign ld_ready  = (state_q == S_IDLE) && !count_q[AW];
  assign ld_we     = ld_valid && ld_ready && !clear;
  assign go_start  = (state_q == S_IDLE) && start && !clear && (count_q != '0);
  assign count_m1  = count_q - 1'b1;
  assign last_word = ({1'b0, rd_ptr_q} == count_m1);

  assign instruccion = instr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign issued_cnt  = issued_q;

  // RAW check of the candidate against every valid in-flight writer
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HL; i++)
      if (hv_q[i] && (hw_q[i] == cand[9:5] || hw_q[i] == cand[4:0]))
        hazard = 1'b1;
  end

  // Program buffer write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (ld_we) mem[count_q[AW-1:0]] <= ld_data;
  end

  // Load/issue/drain control with registered outputs and hazard history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      issued_q <= '0;
      drain_q  <= '0;
      instr_q  <= NOP_W;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < HL; i++) begin
        hv_q[i] <= 1'b0;
        hw_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          instr_q <= NOP_W;
          if (clear)      count_q <= '0;
          else if (ld_we) count_q <= count_q + 1'b1;
          if (go_start) begin
            rd_ptr_q <= '0;
            issued_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_ISSUE;
            for (int i = 0; i < HL; i++) hv_q[i] <= 1'b0;
          end else if (start && !clear) begin
            // empty program: report completion without running
            done_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          for (int i = HL - 1; i > 0; i--) begin
            hv_q[i] <= hv_q[i-1];
            hw_q[i] <= hw_q[i-1];
          end
          if (hazard) begin
            instr_q <= NOP_W;
            hv_q[0] <= 1'b0;
            hw_q[0] <= '0;
          end else begin
            instr_q  <= cand;
            rd_ptr_q <= rd_ptr_q + 1'b1;
            issued_q <= issued_q + 1'b1;
            hv_q[0]  <= (HAZARD_DIST > 1) && cand_wr;
            hw_q[0]  <= cand[14:10];
            if (last_word) begin
              drain_q <= '0;
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          instr_q <= NOP_W;
          if (drain_q == 3'(HAZARD_DIST - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef INSTR_ISSUE_STALL_CNT_EN
  logic [15:0] stall_q;
  assign stall_cnt = stall_q;

  // Saturating count of hazard bubbles in the current/last run
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             stall_q <= '0;
    else if (go_start)                                   stall_q <= '0;
    else if (state_q == S_ISSUE && hazard && stall_q != 16'hFFFF)
                                                         stall_q <= stall_q + 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: randomized and directed checks of instr_issue against a
// list-based model of the issue rules (writer history as a queue of WAs).
module tb_instr_issue;
  localparam int AW = 4;
  localparam int HD = 3;
  localparam logic [18:0] NOP = 19'h78000;

  logic        clk = 1'b0;
  logic        rst, ld_valid, ld_ready, clear, start, busy, done;
  logic [18:0] ld_data, instruccion;
  logic [AW:0] issued_cnt;
`ifdef INSTR_ISSUE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [18:0] prog[$];
  logic [18:0] exp_q[$];
  logic [18:0] first_run[$];
  int          exp_stalls;

  always #5 clk = ~clk;

  instr_issue #(.AW(AW), .HAZARD_DIST(HD)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .clear(clear), .start(start),
    .instruccion(instruccion), .busy(busy), .done(done),
    .issued_cnt(issued_cnt)
`ifdef INSTR_ISSUE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [18:0] mk(input int op, input int wa, input int r1, input int r2);
    mk = {4'(op), 5'(wa), 5'(r1), 5'(r2)};
  endfunction

  // Expected output stream from the first issue cycle through the done cycle
  task automatic model();
    int hist[$];
    int i, op, wa, r1, r2;
    bit hz;
    exp_q.delete();
    exp_stalls = 0;
    i = 0;
    while (i < prog.size()) begin
      op = int'(prog[i][18:15]); wa = int'(prog[i][14:10]);
      r1 = int'(prog[i][9:5]);   r2 = int'(prog[i][4:0]);
      hz = 0;
      foreach (hist[j]) if (hist[j] >= 0 && (hist[j] == r1 || hist[j] == r2)) hz = 1;
      if (hz) begin
        exp_q.push_back(NOP);
        exp_stalls++;
        hist.push_front(-1);
      end else begin
        exp_q.push_back(prog[i]);
        hist.push_front((op != 15 && op < 8) ? wa : -1);
        i++;
      end
      while (hist.size() > HD - 1) void'(hist.pop_back());
    end
    repeat (HD) exp_q.push_back(NOP);
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic do_load();
    foreach (prog[i]) begin
      ld_valid = 1'b1; ld_data = prog[i];
      total++;
      if (ld_ready !== 1'b1) begin
        bad++; $display("FAIL load_ready idx=%0d got=%b want=1", i, ld_ready);
      end
      step();
    end
    ld_valid = 1'b0;
  endtask

  // Start the loaded program and compare every output cycle with the model
  task automatic run_check(input string name, input bit inject);
    int len;
    model();
    len = exp_q.size();
    first_run.delete();
    start = 1'b1; step(); start = 1'b0;
    total++;
    if (busy !== 1'b1 || instruccion !== NOP) begin
      bad++; $display("FAIL %s_start busy=%b instr=%h want busy=1 instr=%h", name, busy, instruccion, NOP);
    end
    for (int k = 1; k <= len; k++) begin
      step();
      first_run.push_back(instruccion);
      if (inject && k == 2) begin
        total++;
        if (ld_ready !== 1'b0) begin
          bad++; $display("FAIL %s_ldready_busy got=%b want=0", name, ld_ready);
        end
        start = 1'b1; ld_valid = 1'b1; ld_data = 19'h12345;
      end else begin
        start = 1'b0; ld_valid = 1'b0;
      end
      total++;
      if (instruccion !== exp_q[k-1] || done !== (k == len) || busy !== (k < len)) begin
        bad++;
        $display("FAIL %s_cyc%0d instr=%h done=%b busy=%b want instr=%h done=%b busy=%b",
                 name, k, instruccion, done, busy, exp_q[k-1], (k == len), (k < len));
      end
    end
    start = 1'b0; ld_valid = 1'b0;
    total++;
    if (issued_cnt !== (AW+1)'(prog.size())) begin
      bad++; $display("FAIL %s_issued got=%0d want=%0d", name, issued_cnt, prog.size());
    end
`ifdef INSTR_ISSUE_STALL_CNT_EN
    total++;
    if (stall_cnt !== 16'(exp_stalls)) begin
      bad++; $display("FAIL %s_stall got=%0d want=%0d", name, stall_cnt, exp_stalls);
    end
`endif
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || instruccion !== NOP) begin
      bad++; $display("FAIL %s_after done=%b busy=%b instr=%h want 0 0 %h", name, done, busy, instruccion, NOP);
    end
  endtask

  // Start with an empty program: one done pulse, nothing issued
  task automatic expect_done_only(input string name);
    start = 1'b1; step(); start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || instruccion !== NOP || ld_ready !== 1'b1) begin
      bad++; $display("FAIL %s_pulse done=%b busy=%b instr=%h rdy=%b want 1 0 %h 1", name, done, busy, instruccion, ld_ready, NOP);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s_idle done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    total++;
    if (instruccion !== NOP || busy !== 1'b0 || done !== 1'b0 || ld_ready !== 1'b1 || issued_cnt !== '0) begin
      bad++; $display("FAIL reset instr=%h busy=%b done=%b rdy=%b iss=%0d want %h 0 0 1 0", instruccion, busy, done, ld_ready, issued_cnt, NOP);
    end
    rst = 1'b0; step();
  endtask

  task automatic test_reset_mid_issue();
    prog = '{mk(0,3,1,2), mk(1,4,5,6), mk(2,5,7,8), mk(3,6,9,10)};
    do_load();
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    #2 rst = 1'b1; #1;
    total++;
    if (instruccion !== NOP || busy !== 1'b0 || ld_ready !== 1'b1 || issued_cnt !== '0) begin
      bad++; $display("FAIL rst_mid instr=%h busy=%b rdy=%b iss=%0d want %h 0 1 0", instruccion, busy, ld_ready, issued_cnt, NOP);
    end
    step(); rst = 1'b0;
    expect_done_only("rst_mid_restart");
  endtask

  task automatic test_directed();
    do_clear();
    prog = '{19'h00C22, 19'h01060};
    do_load(); run_check("dependent", 0);
    do_clear();
    prog = '{19'h00C22, 19'h01041};
    do_load(); run_check("independent", 0);
    do_clear();
    prog = '{mk(8,3,1,2), mk(0,4,3,3)};
    do_load(); run_check("nonwriter", 0);
  endtask

  task automatic test_full_buffer();
    int acc;
    do_clear();
    prog.delete();
    acc = 0;
    for (int j = 1; j <= 20; j++) begin
      ld_valid = 1'b1;
      ld_data  = mk($urandom_range(0,15), $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3));
      total++;
      if (ld_ready !== (j <= 16)) begin
        bad++; $display("FAIL full_rdy cyc=%0d got=%b want=%b", j, ld_ready, (j <= 16));
      end
      if (ld_ready === 1'b1) begin
        acc++; prog.push_back(ld_data);
      end
      step();
    end
    ld_valid = 1'b0;
    total++;
    if (acc != 16) begin
      bad++; $display("FAIL full_accepted got=%0d want=16", acc);
    end
    run_check("full", 0);
    clear = 1'b1; ld_valid = 1'b1; ld_data = 19'h00001; step();
    clear = 1'b0; ld_valid = 1'b0;
    expect_done_only("clear_with_load");
  endtask

  task automatic test_back_to_back();
    logic [18:0] saved[$];
    do_clear();
    prog = '{mk(0,1,2,3), mk(1,2,1,0), mk(15,3,0,0), mk(2,0,2,2), mk(9,1,0,1)};
    do_load();
    run_check("rerun_a", 1);
    saved = first_run;
    run_check("rerun_b", 0);
    total++;
    if (saved != first_run) begin
      bad++; $display("FAIL rerun_identical first=%p second=%p", saved, first_run);
    end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 10; t++) begin
      do_clear();
      prog.delete();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++)
        prog.push_back(mk($urandom_range(0,15), $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3)));
      do_load();
      run_check($sformatf("rand%0d", t), 0);
    end
  endtask

  initial begin
    rst = 1'b0; ld_valid = 1'b0; ld_data = '0; clear = 1'b0; start = 1'b0;
    #1;
    test_reset();
    test_reset_mid_issue();
    test_directed();
    test_full_buffer();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
- Instruction source for the 19-bit pipelined datapath (4b opcode, 5b WA, 5b RA1, 5b RA2); drives its `instruccion` input.
- A host loads a program into an internal buffer. The block then issues one instruction per cycle.
- The datapath has no forwarding. This block detects RAW hazards against in-flight register writes and inserts NOP bubbles.
- After the last instruction it drains the pipeline, then signals completion.

Parameters:
- AW, 4, program buffer address width; DEPTH = 2**AW entries.
- NOP_OPCODE, 4'hF, opcode that writes nothing; NOP word = {NOP_OPCODE, 15'b0}.
- WR_MASK, 16'h00FF, bit i = 1 means opcode i writes register WA.
- HAZARD_DIST, 3, issue-slot distance from a writer to the earliest slot that can read its result; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ld_valid  in  1  host offers ld_data
- ld_ready  out  1  buffer accepts a word this cycle
- ld_data  in  19  instruction word to append
- clear  in  1  empty the program (honoured in IDLE only)
- start  in  1  run the loaded program
- instruccion  out  19  registered instruction to the datapath
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse at end of run
- issued_cnt  out  AW+1  program instructions issued in current/last run

Behaviour:
- States:
  - IDLE: ld_ready = (count < DEPTH).
  - Load: ld_valid && ld_ready writes buf[count], count++. count saturates at DEPTH; ld_ready is low when full.
  - clear in IDLE: count <= 0. If clear and ld_valid occur together, clear wins and no write happens.
  - start in IDLE with count > 0: rd_ptr <= 0, issued_cnt <= 0, hazard history cleared, go to ISSUE.
  - start in IDLE with count == 0: done pulses the next cycle; no issue; stay IDLE.
  - ld_ready = 0 and start/clear are ignored outside IDLE.
- ISSUE, every cycle, candidate C = buf[rd_ptr]:
  - Hazard when C.RA1 or C.RA2 equals WA of any valid entry in the last HAZARD_DIST-1 issued slots.
  - A slot is valid only if its opcode is not NOP_OPCODE and its WR_MASK bit is set.
  - Hazard: instruccion <= NOP; rd_ptr holds; a NOP (invalid) slot is pushed into history.
  - No hazard: instruccion <= C; rd_ptr++, issued_cnt++; C's (write-valid, WA) is pushed into history.
  - Issuing entry count-1: go to DRAIN.
- DRAIN:
  - Emit NOP for exactly HAZARD_DIST cycles.
  - Then done pulses one cycle, go to IDLE.
  - count and buffer contents are retained, so start re-runs the same program.
- IDLE output: instruccion = NOP.
- Latency: start sampled at edge E0; the first program word appears on instruccion after edge E1. A hazard-free N-word program is busy for N + HAZARD_DIST cycles.
- History is a shift register of depth HAZARD_DIST-1. HAZARD_DIST = 1 means hazard detection is never active.
- Reset (async, any state, including mid-run):
  - state = IDLE, instruccion = NOP, count = 0, rd_ptr = 0, issued_cnt = 0, busy = 0, done = 0, history cleared.
  - Buffer RAM is not reset.
- busy is registered and coincides with the ISSUE/DRAIN states.

Optional Feature:
- Macro: INSTR_ISSUE_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0], counting hazard NOPs inserted in ISSUE.
  - Cleared on start and on reset; saturates at 16'hFFFF.
  - Holds its value in IDLE.
- When undefined: no port and no counter logic.

Test Plan:
- Reset mid-ISSUE: load 4 words, start, assert rst on cycle 2 → instruccion = 19'h78000, busy = 0, ld_ready = 1, count = 0 immediately. A later start produces only a done pulse.
- Dependent pair: load 19'h00C22 (op0, WA3, RA1 1, RA2 2) and 19'h01060 (WA4, RA1 3), start → instruccion sequence 00C22, 78000, 78000, 01060, then 3 NOPs, done. issued_cnt = 2; stall_cnt = 2 with the macro.
- Independent pair: 19'h00C22 then 19'h01041 (reads R2, R1) → back-to-back issue, no bubbles, done on the 5th cycle after the first issue.
- Non-writing producer: opcode 8 (WR_MASK bit 0) writing WA3, followed by a reader of R3 → no stall.
- Full buffer: hold ld_valid for 20 cycles with AW = 4 → exactly 16 accepted, ld_ready low from the 17th cycle. clear plus ld_valid together → count = 0, nothing written.
- Re-run and ignore: during busy, pulse start and ld_valid → ignored. After done, start again → identical output sequence.
